// File: rtl/qp_pkg.sv
// rtl/qp_pkg.sv - shared step-direction constants and modulo-depth step helper for the queue-pointer file.
package qp_pkg;

  localparam logic QDIR_UP = 1'b0;
  localparam logic QDIR_DN = 1'b1;

  // Widest pointer the helper supports; cells zero-extend into this width.
  localparam int QP_MAX_W = 16;
  localparam logic [QP_MAX_W:0] QP_ONE = (QP_MAX_W+1)'(1);

  // Returns {wrap, next}; the compare against depth is explicit so that
  // DEPTH < 2**QP_W wraps correctly without relying on natural overflow.
  function automatic logic [QP_MAX_W+1:0] qp_step(input logic [QP_MAX_W:0] p,
                                                  input logic             dir,
                                                  input logic [QP_MAX_W:0] depth);
    logic             wrap;
    logic [QP_MAX_W:0] nxt;
    if (dir == QDIR_UP) begin
      wrap = (p == depth - QP_ONE);
      nxt  = wrap ? '0 : p + QP_ONE;
    end else begin
      wrap = (p == '0);
      nxt  = wrap ? depth - QP_ONE : p - QP_ONE;
    end
    return {wrap, nxt};
  endfunction

endpackage

// File: rtl/qp_cell.sv
// rtl/qp_cell.sv - one task's pointer register and sticky wrap flag with load/step logic.
// Optional shadow snapshot/restore under QP_FILE_SNAPSHOT_EN.
module qp_cell
  import qp_pkg::*;
#(
  parameter int QP_W   = 4,
  parameter int DEPTH  = 16,
  parameter int RST_QP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
`ifdef QP_FILE_SNAPSHOT_EN
  input  logic            snap,
  input  logic            restore,
`endif
  input  logic            ld,
  input  logic            st,
  input  logic            dir,
  input  logic [QP_W-1:0] ld_qp,
  output logic [QP_W-1:0] qp,
  output logic            wrap
);

  localparam logic [QP_W-1:0] RST_V = QP_W'(RST_QP);

  logic [QP_W-1:0]     qp_q, qp_d;
  logic                wrap_q, wrap_d;
  logic [QP_MAX_W+1:0] step_res;
  logic [QP_W-1:0]     step_qp;
  logic                step_wrap;
  logic                unused_step_hi;

  assign step_res       = qp_step((QP_MAX_W+1)'(qp_q), dir, (QP_MAX_W+1)'(DEPTH));
  assign step_wrap      = step_res[QP_MAX_W+1];
  assign step_qp        = step_res[QP_W-1:0];
  assign unused_step_hi = ^step_res[QP_MAX_W:QP_W];

  // A legal load always beats a step and clears the sticky flag.
  always_comb begin
    qp_d   = qp_q;
    wrap_d = wrap_q;
    if (ld) begin
      qp_d   = ld_qp;
      wrap_d = 1'b0;
    end else if (st) begin
      qp_d   = step_qp;
      wrap_d = wrap_q | step_wrap;
    end
  end

`ifdef QP_FILE_SNAPSHOT_EN
  logic [QP_W-1:0] sh_qp_q;
  logic            sh_wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      qp_q      <= RST_V;
      wrap_q    <= 1'b0;
      sh_qp_q   <= RST_V;
      sh_wrap_q <= 1'b0;
    end else if (!hold) begin
      if (restore) begin
        qp_q   <= sh_qp_q;
        wrap_q <= sh_wrap_q;
      end else begin
        if (snap) begin
          sh_qp_q   <= qp_q;
          sh_wrap_q <= wrap_q;
        end
        qp_q   <= qp_d;
        wrap_q <= wrap_d;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      qp_q   <= RST_V;
      wrap_q <= 1'b0;
    end else if (!hold) begin
      qp_q   <= qp_d;
      wrap_q <= wrap_d;
    end
  end
`endif

  assign qp   = qp_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/qp_file_multi.sv
// rtl/qp_file_multi.sv - multi-task queue-pointer register file: selector decode, read mux, illegal-load error.
// Optional snap/restore ports under QP_FILE_SNAPSHOT_EN.
module qp_file_multi
  import qp_pkg::*;
#(
  parameter int TASKS  = 4,
  parameter int QP_W   = 4,
  parameter int DEPTH  = 16,
  parameter int RST_QP = 0,
  localparam int TS_W  = (TASKS > 1) ? $clog2(TASKS) : 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef QP_FILE_SNAPSHOT_EN
  input  logic             snap,
  input  logic             restore,
`endif
  input  logic [TS_W-1:0]  r_ts,
  input  logic [TS_W-1:0]  w_ts,
  input  logic             hold,
  input  logic             ws,
  input  logic             rs,
  input  logic             q_dir,
  input  logic [QP_W-1:0]  i_qp,
  output logic [QP_W-1:0]  o_qp,
  output logic [TASKS-1:0] o_wrap,
  output logic             o_err
);

  logic [QP_W-1:0] qp_all [TASKS];
  logic            ld_legal;
  logic            err_q;

  // Widened compare so DEPTH == 2**QP_W is representable.
  assign ld_legal = ({1'b0, i_qp} < (QP_W+1)'(DEPTH));

  for (genvar t = 0; t < TASKS; t++) begin : g_cell
    qp_cell #(
      .QP_W  (QP_W),
      .DEPTH (DEPTH),
      .RST_QP(RST_QP)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
`ifdef QP_FILE_SNAPSHOT_EN
      .snap   (snap),
      .restore(restore),
`endif
      .ld     (ws & ld_legal & (w_ts == TS_W'(t))),
      .st     (rs & (r_ts == TS_W'(t))),
      .dir    (q_dir),
      .ld_qp  (i_qp),
      .qp     (qp_all[t]),
      .wrap   (o_wrap[t])
    );
  end

  // Out-of-range selectors match no cell and read as zero.
  always_comb begin
    o_qp = '0;
    for (int t = 0; t < TASKS; t++) begin
      if (r_ts == TS_W'(t)) o_qp = qp_all[t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hold) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ws & ~ld_legal;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_qp_file_multi.sv
// tb/tb_qp_file_multi.sv - scoreboard bench for qp_file_multi (TASKS=4, QP_W=4, DEPTH=12, RST_QP=0).
module tb_qp_file_multi;

  localparam int TASKS = 4;
  localparam int QP_W  = 4;
  localparam int DEPTH = 12;

  typedef struct {
    logic [QP_W-1:0]  qp;
    logic [TASKS-1:0] wrap;
    logic             err;
    string            tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, hold, ws, rs, q_dir;
  logic [1:0]       r_ts, w_ts;
  logic [QP_W-1:0]  i_qp;
  logic [QP_W-1:0]  o_qp;
  logic [TASKS-1:0] o_wrap;
  logic             o_err;
`ifdef QP_FILE_SNAPSHOT_EN
  logic             snap, restore;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  int   m_ptr [TASKS];
  bit   m_wrap[TASKS];
  int   m_sh  [TASKS];
  bit   m_shw [TASKS];
  bit   m_err;
  bit   m_valid = 0;

  always #5 clk = ~clk;

  qp_file_multi #(.TASKS(TASKS), .QP_W(QP_W), .DEPTH(DEPTH), .RST_QP(0)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef QP_FILE_SNAPSHOT_EN
    .snap  (snap),
    .restore(restore),
`endif
    .r_ts  (r_ts),
    .w_ts  (w_ts),
    .hold  (hold),
    .ws    (ws),
    .rs    (rs),
    .q_dir (q_dir),
    .i_qp  (i_qp),
    .o_qp  (o_qp),
    .o_wrap(o_wrap),
    .o_err (o_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".o_qp"},   32'(o_qp),   32'(e.qp));
        chk({e.tag, ".o_wrap"}, 32'(o_wrap), 32'(e.wrap));
        chk({e.tag, ".o_err"},  32'(o_err),  32'(e.err));
      end
    end
  end

  // Reference model: per-task pointers as integers, stepping by modular arithmetic.
  task automatic model_edge(input bit r, h, w_s, r_s, d, input int wt, rt, iq, input bit sn, rsto);
    int nptr[TASKS];
    bit nwrap[TASKS];
    bit legal;
    if (r) begin
      for (int t = 0; t < TASKS; t++) begin
        m_ptr[t] = 0; m_wrap[t] = 0; m_sh[t] = 0; m_shw[t] = 0;
      end
      m_err   = 0;
      m_valid = 1;
      return;
    end
    if (h) begin
      m_err = 0;
      return;
    end
    legal = (iq < DEPTH);
    m_err = w_s && !legal;
    nptr  = m_ptr;
    nwrap = m_wrap;
`ifdef QP_FILE_SNAPSHOT_EN
    if (rsto) begin
      m_ptr  = m_sh;
      m_wrap = m_shw;
      return;
    end
    if (sn) begin
      m_sh  = m_ptr;
      m_shw = m_wrap;
    end
`endif
    if (r_s && !(w_s && legal && wt == rt)) begin
      if (!d) begin
        if (m_ptr[rt] == DEPTH - 1) nwrap[rt] = 1;
        nptr[rt] = (m_ptr[rt] + 1) % DEPTH;
      end else begin
        if (m_ptr[rt] == 0) nwrap[rt] = 1;
        nptr[rt] = (m_ptr[rt] + DEPTH - 1) % DEPTH;
      end
    end
    if (w_s && legal) begin
      nptr[wt]  = iq;
      nwrap[wt] = 0;
    end
    m_ptr  = nptr;
    m_wrap = nwrap;
  endtask

  task automatic cyc(input string tag, input bit r, h, w_s, r_s, d, input int wt, rt, iq,
                     input bit sn = 0, rsto = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hold = h; ws = w_s; rs = r_s; q_dir = d;
    w_ts = 2'(wt); r_ts = 2'(rt); i_qp = QP_W'(iq);
`ifdef QP_FILE_SNAPSHOT_EN
    snap = sn; restore = rsto;
`endif
    if (m_valid) begin
      e.qp  = QP_W'(m_ptr[rt]);
      for (int t = 0; t < TASKS; t++) e.wrap[t] = m_wrap[t];
      e.err = m_err;
      e.tag = tag;
      sb.push_back(e);
    end
    model_edge(r, h, w_s, r_s, d, wt, rt, iq, sn, rsto);
  endtask

  task automatic rd(input string tag, input int rt);
    cyc(tag, 0, 0, 0, 0, 0, 0, rt, 0);
  endtask

  initial begin
    int wt, rt, iq;
    bit w_s, r_s;
    rst = 1; hold = 0; ws = 0; rs = 0; q_dir = 0; r_ts = 0; w_ts = 0; i_qp = 0;
`ifdef QP_FILE_SNAPSHOT_EN
    snap = 0; restore = 0;
`endif
    cyc("reset0", 1, 0, 1, 1, 0, 0, 0, 5);
    cyc("reset1", 1, 0, 1, 1, 0, 0, 0, 5);
    for (int t = 0; t < TASKS; t++) rd("reset_rd", t);

    cyc("load2", 0, 0, 1, 0, 0, 2, 2, 10);
    for (int k = 0; k < 3; k++) cyc("up_wrap", 0, 0, 0, 1, 0, 0, 2, 0);
    rd("up_wrap_end", 2);

    cyc("dn_wrap", 0, 0, 0, 1, 1, 0, 1, 0);
    rd("dn_wrap_rd", 1);
    cyc("clr_load", 0, 0, 1, 0, 0, 1, 1, 4);
    rd("clr_load_rd", 1);

    cyc("same_task", 0, 0, 1, 1, 0, 3, 3, 7);
    rd("same_task_rd", 3);
    cyc("diff_task", 0, 0, 1, 1, 0, 0, 3, 2);
    rd("diff_rd0", 0);
    rd("diff_rd3", 3);

    cyc("illegal", 0, 0, 1, 0, 0, 0, 0, 13);
    rd("illegal_err", 0);
    rd("illegal_clr", 0);
    cyc("illegal_hold", 0, 0, 1, 0, 0, 0, 0, 15);
    cyc("hold", 0, 1, 1, 1, 0, 0, 0, 5);
    rd("hold_rd", 0);

`ifdef QP_FILE_SNAPSHOT_EN
    for (int t = 0; t < TASKS; t++) cyc("snap_ld", 0, 0, 1, 0, 0, t, t, t + 1);
    cyc("snap", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("snap_st", 0, 0, 0, 1, 1, 0, 0, 0);
    cyc("snap_st", 0, 0, 0, 1, 1, 0, 0, 0);
    cyc("restore", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int t = 0; t < TASKS; t++) rd("restore_rd", t);
    cyc("pre_both", 0, 0, 0, 1, 0, 0, 1, 0);
    cyc("both", 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    rd("both_rd", 1);
`endif

    for (int n = 0; n < 400; n++) begin
      wt  = $urandom_range(0, TASKS - 1);
      rt  = $urandom_range(0, TASKS - 1);
      iq  = $urandom_range(0, 15);
      w_s = ($urandom_range(0, 1) == 1);
      r_s = ($urandom_range(0, 1) == 1);
      if (w_s && iq >= DEPTH && wt == rt) r_s = 0;
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0), w_s, r_s,
          $urandom_range(0, 1) == 1, wt, rt, iq,
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    rd("final", 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qp_file_multi.md
Name: qp_file_multi

Overview:
- Parametrised multi-task queue-pointer register file; generalises the single-task 4-bit queue pointer file.
- Holds one QP_W-bit queue pointer per task, with modulo-DEPTH wrap-around, up/down stepping and per-task wrap flags.
- Sits between instruction decode (task selectors, step/load controls) and queue-addressing logic in the qisp core.

Parameters:
- TASKS, 4: number of task contexts; at least 2.
- QP_W, 4: pointer width in bits.
- DEPTH, 16: queue depth; pointers wrap modulo DEPTH; 2 <= DEPTH <= 2**QP_W.
- RST_QP, 0: reset value of every pointer; must be < DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- r_ts  in  $clog2(TASKS)  read/step task selector.
- w_ts  in  $clog2(TASKS)  write (load) task selector.
- hold  in  1  freeze all pointer and flag updates this cycle.
- ws  in  1  load i_qp into pointer[w_ts].
- rs  in  1  step pointer[r_ts] by one.
- q_dir  in  1  step direction: 0 = +1, 1 = -1.
- i_qp  in  QP_W  new pointer value for a load.
- o_qp  out  QP_W  pointer[r_ts], combinational from the register; shows the pre-update value.
- o_wrap  out  TASKS  sticky per-task wrap flags.
- o_err  out  1  one-cycle pulse: the previous cycle attempted a load with i_qp >= DEPTH.

Behaviour:
- Reset: rst=1 at a clock edge sets every pointer to RST_QP, o_wrap to 0 and o_err to 0. Reset overrides all other inputs, including hold. Reset mid-operation discards any pending load or step.
- Hold: hold=1 blocks every load, step and flag change. o_err still updates, to 0.
- Load: ws=1, hold=0, i_qp < DEPTH: pointer[w_ts] <= i_qp and o_wrap[w_ts] <= 0.
- Illegal load: ws=1, hold=0, i_qp >= DEPTH: the pointer is unchanged and o_err pulses 1 on the next cycle.
- Step up: rs=1, hold=0, q_dir=0. Pointer DEPTH-1 becomes 0 and sets o_wrap[r_ts]; any other value p becomes p+1.
- Step down: rs=1, hold=0, q_dir=1. Pointer 0 becomes DEPTH-1 and sets o_wrap[r_ts]; any other value p becomes p-1.
- Arithmetic is done in QP_W+1 bits, then the wrap compare is applied; no reliance on natural 2**QP_W overflow.
- Same task, ws=1 and rs=1 in one cycle: the load wins, the step is dropped, and the flag is cleared by the load.
- Different tasks: load and step both take effect in the same cycle.
- A wrap flag is cleared only by a legal load to that task, or by reset.
- Latency: updates become visible on o_qp the cycle after the edge. There is no same-cycle bypass.
- Selectors >= TASKS are ignored: no update, and o_qp reads 0.

Optional Feature:
- Macro: QP_FILE_SNAPSHOT_EN.
- When defined, two ports are added: snap (in, 1) and restore (in, 1), with one shadow register per task.
  - snap=1: all pointers and wrap flags are copied to the shadow.
  - restore=1: the shadow is copied back to the live registers, with priority over load and step.
  - snap and restore together: restore wins.
  - hold blocks both snap and restore. Reset clears the shadow to RST_QP and 0.
- When undefined, the ports and shadow registers are absent and behaviour is exactly as above.

Decomposition:
- Package qp_pkg:
  - step-direction constants QDIR_UP = 0 and QDIR_DN = 1;
  - function qp_step(p, dir, depth), returning {wrap, next}.
- Natural sub-module: qp_cell, one task's pointer register plus wrap flag and load/step logic, instantiated TASKS times with a generate loop. The top level does selector decode, the o_qp mux and o_err.

Test Plan (TASKS=4, QP_W=4, DEPTH=12, RST_QP=0):
- Reset: hold rst 2 cycles with ws=rs=1 and i_qp=5 -> every task reads o_qp=0, o_wrap=0000, o_err=0.
- Load then step up across the wrap: load task 2 with 10, then rs=1, q_dir=0 for 3 cycles -> o_qp sequence 10, 11, 0, 1; o_wrap[2]=1 from the cycle after the 11->0 step.
- Step down across the wrap: task 1 at 0, rs=1, q_dir=1 -> o_qp=11, o_wrap[1]=1; a later legal load to task 1 clears it.
- Same-task collision: w_ts=r_ts=3, ws=rs=1, i_qp=7 -> pointer[3]=7, no step applied. Different tasks (w_ts=0, r_ts=3) -> pointer[0]=i_qp and pointer[3] steps, both in the same cycle.
- Illegal load and hold: ws=1 with i_qp=13 -> pointer unchanged, o_err=1 for exactly one cycle. hold=1 with ws=rs=1 -> no pointer or flag change.
- With QP_FILE_SNAPSHOT_EN:
  - snap at pointers {1,2,3,4}, step task 0 twice, then restore -> pointers {1,2,3,4} and the flags match the snapshot;
  - snap and restore asserted together -> the restore takes effect.
